// File: rtl/lc3_decode_issue_if.sv
// Bundle of the decode/issue stage connections: fetch handshake, register-file
// read port, issue slot towards execute, writeback retire port and scoreboard.
interface lc3_decode_issue_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;

    logic [2:0]        rf_sr1;
    logic [2:0]        rf_sr2;
    logic [DATA_W-1:0] rf_sr1_data;
    logic [DATA_W-1:0] rf_sr2_data;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_op;
    logic [2:0]        out_dr;
    logic              out_wr;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;

    logic              wb_valid;
    logic [2:0]        wb_dr;
    logic [NREG-1:0]   busy_o;

    // Environment side: fetch, register file, execute and writeback.
    modport master (
        output in_valid, in_instr, rf_sr1_data, rf_sr2_data, out_ready, wb_valid, wb_dr,
        input  in_ready, rf_sr1, rf_sr2, out_valid, out_op, out_dr, out_wr, out_a, out_b, busy_o
    );

    // Decode/issue stage side.
    modport slave (
        input  in_valid, in_instr, rf_sr1_data, rf_sr2_data, out_ready, wb_valid, wb_dr,
        output in_ready, rf_sr1, rf_sr2, out_valid, out_op, out_dr, out_wr, out_a, out_b, busy_o
    );
endinterface

// File: rtl/lc3_decode_issue.sv
// LC-3 decode/operand-fetch stage: decodes one instruction per handshake,
// reads operands from the register file, fills a one-entry issue slot and
// tracks in-flight destinations in a busy scoreboard to stall RAW/WAW hazards.
module lc3_decode_issue #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input logic             clk,
    input logic             rst_n,
    lc3_decode_issue_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    logic [3:0]        dec_op;
    logic [2:0]        dec_dr;
    logic [2:0]        dec_sr1;
    logic [2:0]        dec_sr2;
    logic              is_add_and;
    logic              is_not;
    logic              wr_next;
    logic              needs_sr1;
    logic              needs_sr2;
    logic              hazard;
    logic              ready;
    logic              accept;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] b_next;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;

    logic              slot_valid;
    logic [3:0]        slot_op;
    logic [2:0]        slot_dr;
    logic              slot_wr;
    logic [DATA_W-1:0] slot_a;
    logic [DATA_W-1:0] slot_b;

    // Field extraction, source requirements and operand B selection for the incoming word.
    always_comb begin
        dec_op     = bus.in_instr[15:12];
        dec_dr     = bus.in_instr[11:9];
        dec_sr1    = bus.in_instr[8:6];
        dec_sr2    = bus.in_instr[2:0];
        is_add_and = (dec_op == OP_ADD) || (dec_op == OP_AND);
        is_not     = (dec_op == OP_NOT);
        wr_next    = is_add_and || is_not;
        needs_sr1  = wr_next;
        needs_sr2  = is_add_and && !bus.in_instr[5];
        imm_sext   = {{(DATA_W-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
        if (is_not) begin
            b_next = '0;
        end else if (bus.in_instr[5]) begin
            b_next = imm_sext;
        end else begin
            b_next = bus.rf_sr2_data;
        end
    end

    // Hazard check against the registered scoreboard; a clearing writeback only helps next cycle.
    always_comb begin
        hazard = (needs_sr1 && busy[dec_sr1]) ||
                 (needs_sr2 && busy[dec_sr2]) ||
                 (wr_next   && busy[dec_dr]);
        ready  = rst_n && (!slot_valid || bus.out_ready) && !hazard;
        accept = bus.in_valid && ready;
    end

    // Scoreboard update: retire first, then mark the new destination so a same-register set wins.
    always_comb begin
        busy_next = busy;
        if (bus.wb_valid) begin
            busy_next[bus.wb_dr] = 1'b0;
        end
        if (accept && wr_next) begin
            busy_next[dec_dr] = 1'b1;
        end
    end

    // Scoreboard register; reset forgets every in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Issue slot: load on accept, empty when consumed without refill, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
            slot_op    <= '0;
            slot_dr    <= '0;
            slot_wr    <= 1'b0;
            slot_a     <= '0;
            slot_b     <= '0;
        end else if (accept) begin
            slot_valid <= 1'b1;
            slot_op    <= dec_op;
            slot_dr    <= dec_dr;
            slot_wr    <= wr_next;
            slot_a     <= bus.rf_sr1_data;
            slot_b     <= b_next;
        end else if (bus.out_ready) begin
            slot_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.rf_sr1    = dec_sr1;
    assign bus.rf_sr2    = dec_sr2;
    assign bus.out_valid = slot_valid;
    assign bus.out_op    = slot_op;
    assign bus.out_dr    = slot_dr;
    assign bus.out_wr    = slot_wr;
    assign bus.out_a     = slot_a;
    assign bus.out_b     = slot_b;
    assign bus.busy_o    = busy;
endmodule

// File: tb/tb_lc3_decode_issue.sv
// Self-checking bench for lc3_decode_issue: reset checks, a table of decode
// vectors, hand-written hazard/stall sequences and a randomized run against
// a behavioural model of the stage.
module tb_lc3_decode_issue;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: scoreboard as a plain bit per register plus the slot contents.
    bit          m_busy [NREG];
    bit          m_valid;
    logic [3:0]  m_op;
    logic [2:0]  m_dr;
    bit          m_wr;
    logic [15:0] m_a;
    logic [15:0] m_b;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [2:0]  e_sr1;
        logic [2:0]  e_sr2;
        logic [3:0]  e_op;
        logic [2:0]  e_dr;
        logic        e_wr;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [7:0]  e_busy;
    } vec_t;

    vec_t vecs [9];

    // Free-running clock.
    always #5 clk = ~clk;

    lc3_decode_issue_if #(.DATA_W(DATA_W), .NREG(NREG)) bus ();

    lc3_decode_issue #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] instr,
                                 input logic [15:0] d1, input logic [15:0] d2,
                                 input logic ordy, input logic wbv, input logic [2:0] wbd);
        bus.in_valid    = v;
        bus.in_instr    = instr;
        bus.rf_sr1_data = d1;
        bus.rf_sr2_data = d2;
        bus.out_ready   = ordy;
        bus.wb_valid    = wbv;
        bus.wb_dr       = wbd;
    endtask

    function automatic logic [7:0] modelBusy();
        logic [7:0] r;
        for (int k = 0; k < NREG; k++) r[k] = m_busy[k];
        return r;
    endfunction

    task automatic resetModel();
        for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
        m_valid = 1'b0;
        m_op = '0; m_dr = '0; m_wr = 1'b0; m_a = '0; m_b = '0;
    endtask

    // One clock of model-checked operation: compare at the falling edge, advance model at the rising edge.
    task automatic runCycle(input string tag);
        logic [15:0] i;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] bval;
        int          op;
        int          imm;
        bit          alu;
        bit          sreg;
        bit          rdy;
        bit          acc;
        bit          ordy;
        bit          wbv;
        logic [2:0]  wbd;
        @(negedge clk);
        i    = bus.in_instr;
        d1   = bus.rf_sr1_data;
        d2   = bus.rf_sr2_data;
        ordy = bus.out_ready;
        wbv  = bus.wb_valid;
        wbd  = bus.wb_dr;
        op   = int'(i[15:12]);
        alu  = (op == 1) || (op == 5) || (op == 9);
        sreg = ((op == 1) || (op == 5)) && (i[5] == 1'b0);
        rdy  = !m_valid || ordy;
        if (alu  && m_busy[i[8:6]])  rdy = 1'b0;
        if (sreg && m_busy[i[2:0]])  rdy = 1'b0;
        if (alu  && m_busy[i[11:9]]) rdy = 1'b0;
        checkOutput({tag, " in_ready"},  bus.in_ready,  rdy);
        checkOutput({tag, " rf_sr1"},    bus.rf_sr1,    i[8:6]);
        checkOutput({tag, " rf_sr2"},    bus.rf_sr2,    i[2:0]);
        checkOutput({tag, " out_valid"}, bus.out_valid, m_valid);
        checkOutput({tag, " out_op"},    bus.out_op,    m_op);
        checkOutput({tag, " out_dr"},    bus.out_dr,    m_dr);
        checkOutput({tag, " out_wr"},    bus.out_wr,    m_wr);
        checkOutput({tag, " out_a"},     bus.out_a,     m_a);
        if (m_wr) checkOutput({tag, " out_b"}, bus.out_b, m_b);
        checkOutput({tag, " busy_o"},    bus.busy_o,    modelBusy());
        acc = bus.in_valid && rdy;
        if (op == 9) begin
            bval = 16'h0000;
        end else if (i[5]) begin
            imm = int'(i[4:0]);
            if (imm >= 16) imm = imm - 32;
            bval = 16'(imm);
        end else begin
            bval = d2;
        end
        @(posedge clk);
        if (wbv) m_busy[wbd] = 1'b0;
        if (acc) begin
            m_valid = 1'b1;
            m_op    = i[15:12];
            m_dr    = i[11:9];
            m_wr    = alu;
            m_a     = d1;
            m_b     = bval;
            if (alu) m_busy[i[11:9]] = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    // Test sequence: reset, table vectors, hazard sequences, random run, mid-run reset.
    initial begin
        vecs[0] = '{16'h1283, 16'h0002, 16'h0003, 3'd2, 3'd3, 4'h1, 3'd1, 1'b1, 16'h0002, 16'h0003, 8'h02};
        vecs[1] = '{16'h187F, 16'h0010, 16'h1234, 3'd1, 3'd7, 4'h1, 3'd4, 1'b1, 16'h0010, 16'hFFFF, 8'h10};
        vecs[2] = '{16'h5BA5, 16'hABCD, 16'h5555, 3'd6, 3'd5, 4'h5, 3'd5, 1'b1, 16'hABCD, 16'h0005, 8'h20};
        vecs[3] = '{16'h9E3F, 16'h00FF, 16'h7777, 3'd0, 3'd7, 4'h9, 3'd7, 1'b1, 16'h00FF, 16'h0000, 8'h80};
        vecs[4] = '{16'h5042, 16'h0F0F, 16'h3C3C, 3'd1, 3'd2, 4'h5, 3'd0, 1'b1, 16'h0F0F, 16'h3C3C, 8'h01};
        vecs[5] = '{16'h1B70, 16'h8000, 16'h1111, 3'd5, 3'd0, 4'h1, 3'd5, 1'b1, 16'h8000, 16'hFFF0, 8'h20};
        vecs[6] = '{16'h0000, 16'h4444, 16'h2222, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 16'h4444, 16'h0000, 8'h00};
        vecs[7] = '{16'h9A80, 16'h1357, 16'h2468, 3'd2, 3'd0, 4'h9, 3'd5, 1'b1, 16'h1357, 16'h0000, 8'h20};
        vecs[8] = '{16'h3283, 16'h0BAD, 16'h0CAB, 3'd2, 3'd3, 4'h3, 3'd1, 1'b0, 16'h0BAD, 16'h0000, 8'h00};

        resetModel();

        // Reset with a valid ADD presented: nothing may issue and all state reads zero.
        applyStimulus(1'b1, 16'h1283, 16'h0002, 16'h0003, 1'b1, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst in_ready",  bus.in_ready,  1'b0);
        checkOutput("rst out_valid", bus.out_valid, 1'b0);
        checkOutput("rst out_op",    bus.out_op,    4'h0);
        checkOutput("rst out_dr",    bus.out_dr,    3'd0);
        checkOutput("rst out_wr",    bus.out_wr,    1'b0);
        checkOutput("rst out_a",     bus.out_a,     16'h0000);
        checkOutput("rst out_b",     bus.out_b,     16'h0000);
        checkOutput("rst busy_o",    bus.busy_o,    8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post-rst in_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors: issue one op, then retire it while the slot drains.
        for (int n = 0; n < 9; n++) begin
            applyStimulus(1'b1, vecs[n].instr, vecs[n].d1, vecs[n].d2, 1'b1, 1'b0, 3'd0);
            #1;
            checkOutput($sformatf("vec%0d rf_sr1", n), bus.rf_sr1, vecs[n].e_sr1);
            checkOutput($sformatf("vec%0d rf_sr2", n), bus.rf_sr2, vecs[n].e_sr2);
            runCycle($sformatf("vec%0d issue", n));
            checkOutput($sformatf("vec%0d out_valid", n), bus.out_valid, 1'b1);
            checkOutput($sformatf("vec%0d out_op", n),    bus.out_op,    vecs[n].e_op);
            checkOutput($sformatf("vec%0d out_dr", n),    bus.out_dr,    vecs[n].e_dr);
            checkOutput($sformatf("vec%0d out_wr", n),    bus.out_wr,    vecs[n].e_wr);
            checkOutput($sformatf("vec%0d out_a", n),     bus.out_a,     vecs[n].e_a);
            if (vecs[n].e_wr) checkOutput($sformatf("vec%0d out_b", n), bus.out_b, vecs[n].e_b);
            checkOutput($sformatf("vec%0d busy_o", n),    bus.busy_o,    vecs[n].e_busy);
            applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, vecs[n].e_wr, vecs[n].e_dr);
            runCycle($sformatf("vec%0d retire", n));
        end

        // RAW: ADD R4,R1,#-1 waits on R1 until writeback, issuing the cycle after the retire.
        applyStimulus(1'b1, 16'h1283, 16'h0002, 16'h0003, 1'b1, 1'b0, 3'd0);
        runCycle("raw producer");
        applyStimulus(1'b1, 16'h187F, 16'h0010, 16'h0000, 1'b1, 1'b0, 3'd0);
        #1;
        checkOutput("raw stall in_ready", bus.in_ready, 1'b0);
        runCycle("raw stall");
        applyStimulus(1'b1, 16'h187F, 16'h0010, 16'h0000, 1'b1, 1'b1, 3'd1);
        #1;
        checkOutput("raw wb-cycle in_ready", bus.in_ready, 1'b0);
        runCycle("raw wb");
        applyStimulus(1'b1, 16'h187F, 16'h0010, 16'h0000, 1'b1, 1'b0, 3'd0);
        #1;
        checkOutput("raw release in_ready", bus.in_ready, 1'b1);
        runCycle("raw issue");
        checkOutput("raw out_b",  bus.out_b,  16'hFFFF);
        checkOutput("raw out_dr", bus.out_dr, 3'd4);
        checkOutput("raw busy_o", bus.busy_o, 8'h10);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd4);
        runCycle("raw cleanup");

        // Backpressure: AND R5,R6,#5 held in the slot for three cycles, then drained.
        applyStimulus(1'b1, 16'h5BA5, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 3'd0);
        runCycle("bp accept");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0);
            #1;
            checkOutput("bp in_ready", bus.in_ready, 1'b0);
            runCycle("bp hold");
            checkOutput("bp out_valid", bus.out_valid, 1'b1);
            checkOutput("bp out_b",     bus.out_b,     16'h0005);
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd5);
        runCycle("bp drain");
        checkOutput("bp drained out_valid", bus.out_valid, 1'b0);
        checkOutput("bp drained busy_o",    bus.busy_o,    8'h00);

        // WAW on R7: stall, retire, then re-accept alongside another R7 retire; the set must win.
        applyStimulus(1'b1, 16'h9E3F, 16'h00F0, 16'h0000, 1'b1, 1'b0, 3'd0);
        runCycle("waw first");
        applyStimulus(1'b1, 16'h9E3F, 16'h00F0, 16'h0000, 1'b1, 1'b0, 3'd0);
        #1;
        checkOutput("waw stall in_ready", bus.in_ready, 1'b0);
        runCycle("waw stall");
        applyStimulus(1'b1, 16'h9E3F, 16'h00F0, 16'h0000, 1'b1, 1'b1, 3'd7);
        runCycle("waw retire");
        applyStimulus(1'b1, 16'h9E3F, 16'h00F0, 16'h0000, 1'b1, 1'b1, 3'd7);
        #1;
        checkOutput("waw reaccept in_ready", bus.in_ready, 1'b1);
        runCycle("waw reaccept");
        checkOutput("waw busy_o", bus.busy_o, 8'h80);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd7);
        runCycle("waw cleanup");

        // Fill every busy bit with AND Rd,R0,#0 then show a BR still issues untouched.
        for (int d = 1; d <= 8; d++) begin
            applyStimulus(1'b1, 16'h5020 | 16'((d % 8) << 9), 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd0);
            runCycle("fill");
        end
        applyStimulus(1'b1, 16'h0000, 16'h1111, 16'h2222, 1'b1, 1'b0, 3'd0);
        #1;
        checkOutput("br in_ready", bus.in_ready, 1'b1);
        runCycle("br issue");
        checkOutput("br out_valid", bus.out_valid, 1'b1);
        checkOutput("br out_wr",    bus.out_wr,    1'b0);
        checkOutput("br busy_o",    bus.busy_o,    8'hFF);
        for (int d = 0; d < NREG; d++) begin
            applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'(d));
            runCycle("br cleanup");
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] ins;
            int          pick;
            pick = int'($urandom_range(0, 9));
            ins  = 16'($urandom);
            if (pick <= 2)      ins[15:12] = 4'h1;
            else if (pick <= 5) ins[15:12] = 4'h5;
            else if (pick <= 7) ins[15:12] = 4'h9;
            applyStimulus(($urandom_range(0, 4) != 0), ins, 16'($urandom), 16'($urandom),
                          ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
            runCycle("rnd");
        end

        // Reset in the middle of traffic, followed by a stale writeback that must be ignored.
        applyStimulus(1'b1, 16'h5020, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0);
        runCycle("pre-reset");
        rst_n = 1'b0;
        #2;
        checkOutput("midrst out_valid", bus.out_valid, 1'b0);
        checkOutput("midrst busy_o",    bus.busy_o,    8'h00);
        checkOutput("midrst out_op",    bus.out_op,    4'h0);
        resetModel();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runCycle("post-reset wb");
        checkOutput("post-reset busy_o", bus.busy_o, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
